// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a CDC FIFO: issues reads, captures the registered read data
// and re-presents it as a valid/ready stream via a 2-entry buffer. Option: FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_rrdy_i,
  output logic                  fifo_re_o,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]           words_o
`endif
);

  logic [1:0]            cnt_q, cnt_d;
  logic                  infl_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  pop_s;
  logic [2:0]            level_s;
  logic [1:0]            slot_s;

  assign pop_s     = (cnt_q != 2'd0) & m_ready_i;
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = buf0_q;

  // Occupancy after this cycle's capture and pop; gating on it keeps cnt+infl <= 2.
  always_comb begin
    level_s   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop_s};
    cnt_d     = level_s[1:0];
    fifo_re_o = ~rst_i & fifo_rrdy_i & (level_s < 3'd2);
  end

  // Shift on pop, then land the in-flight word in the first free slot.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    slot_s = cnt_q - {1'b0, pop_s};
    if (pop_s) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end
    if (infl_q) begin
      case (slot_s)
        2'd0:    buf0_d = fifo_dout_i;
        2'd1:    buf1_d = fifo_dout_i;
        default: buf1_d = buf1_q;
      endcase
    end else begin
      buf1_d = buf1_d;
    end
  end

  // Control state; a read in flight at reset is dropped with the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      infl_q <= fifo_re_o;
    end
  end

  // Buffer storage needs no reset: it is only observed while cnt is non-zero.
  always_ff @(posedge clk_i) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] words_q, words_d;

  // Accepted-beat counter, wraps naturally at 16 bits.
  always_comb begin
    if (pop_s) begin
      words_d = words_q + 16'd1;
    end else begin
      words_d = words_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      words_q <= 16'd0;
    end else begin
      words_q <= words_d;
    end
  end

  assign words_o = words_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO source model, scoreboard queue of read words,
// per-cycle protocol checks. Counter checks run when FIFO_RD_STREAM_CNT_EN is defined.
module tb_fifo_rd_stream;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       fifo_rrdy_i = 1'b0;
  logic       fifo_re_o;
  logic [7:0] fifo_dout_i = 8'h00;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [7:0] m_data_o;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] words_o;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fifo_rrdy_i(fifo_rrdy_i),
    .fifo_re_o  (fifo_re_o),
    .fifo_dout_i(fifo_dout_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .words_o    (words_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int         vectors = 0;
  int         miscompares = 0;
  int         avail = 0;
  int         pops = 0;
  logic [7:0] next_val = 8'h01;
  logic [7:0] sb_q[$];
  logic       re_s, pop_s, valid_s;
  logic [7:0] data_s;
  logic       prev_valid = 1'b0;
  logic       prev_pop = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs and sample at negedge, then model the FIFO after posedge.
  task automatic cycle(input logic rst, input logic gate, input logic rdy);
    logic [7:0] exp_w;
    @(negedge clk_i);
    rst_i       = rst;
    fifo_rrdy_i = gate && (avail > 0);
    m_ready_i   = rdy;
    #1;
    re_s    = fifo_re_o;
    valid_s = m_valid_o;
    data_s  = m_data_o;
    pop_s   = m_valid_o & m_ready_i;
    check("re_without_rrdy", {31'd0, re_s & ~fifo_rrdy_i}, 32'd0);
    check("occupancy_le_2", {31'd0, sb_q.size() <= 2}, 32'd1);
    if (!rst && !prev_rst && prev_valid && !prev_pop) begin
      check("hold_valid", {31'd0, valid_s}, 32'd1);
      check("hold_data", {24'd0, data_s}, {24'd0, prev_data});
    end
    if (!rst && pop_s) begin
      pops++;
      if (sb_q.size() == 0) begin
        check("pop_unexpected", 32'd1, 32'd0);
      end else begin
        exp_w = sb_q.pop_front();
        check("stream_data", {24'd0, data_s}, {24'd0, exp_w});
      end
    end
    prev_valid = valid_s & ~rst;
    prev_pop   = pop_s;
    prev_data  = data_s;
    prev_rst   = rst;
    @(posedge clk_i);
    #1;
    if (re_s) begin
      fifo_dout_i = next_val;
      sb_q.push_back(next_val);
      next_val = next_val + 8'd1;
      avail--;
    end
  endtask

  initial begin
    int nre;
    int p0;
    int found;
    logic [7:0] exp_first;

    // Reset held 3 cycles with data available.
    avail    = 32;
    next_val = 8'h01;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      check("reset_re", {31'd0, re_s}, 32'd0);
      check("reset_valid", {31'd0, valid_s}, 32'd0);
    end
    sb_q.delete();
    pops = 0;

    // Streaming 0x01..0x20 with constant ready.
    for (int i = 0; i < 36; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      check("stream_re", {31'd0, re_s}, {31'd0, i < 32});
      check("stream_valid", {31'd0, valid_s}, {31'd0, (i >= 2) && (i <= 33)});
      if (i == 2) check("stream_first", {24'd0, data_s}, 32'h01);
    end
    check("stream_count", pops, 32);

    // Backpressure: 5 words available, ready low.
    avail    = 5;
    next_val = 8'h01;
    nre      = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      nre += int'(re_s);
      if (i >= 2) begin
        check("bp_valid", {31'd0, valid_s}, 32'd1);
        check("bp_data", {24'd0, data_s}, 32'h01);
      end
    end
    check("bp_reads", nre, 2);
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      check("bp_release_valid", {31'd0, valid_s}, {31'd0, i < 5});
    end
    check("bp_release_pops", pops - p0, 5);
    check("bp_drained", sb_q.size(), 0);

    // Reset while the buffer is full.
    avail = 6;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    check("mid_full", {31'd0, valid_s}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    sb_q.delete();
    exp_first = next_val;
    cycle(1'b0, 1'b1, 1'b1);
    check("mid_valid_cleared", {31'd0, valid_s}, 32'd0);
    found = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (pop_s && found == 0) begin
        check("mid_next_word", {24'd0, data_s}, {24'd0, exp_first});
        found = 1;
      end
    end
    check("mid_word_seen", found, 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1);
    check("mid_drained", sb_q.size(), 0);

    // Sparse source, random downstream ready, 1000 words.
    avail = 1100;
    p0    = pops;
    for (int cyc = 0; cyc < 8000 && (pops - p0) < 1000; cyc++) begin
      cycle(1'b0, (cyc % 2) == 0, 1'($urandom_range(0, 1)));
    end
    check("sparse_words", pops - p0, 1000);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wrap after 65537 pops, then clear by reset.
    cycle(1'b1, 1'b0, 1'b0);
    sb_q.delete();
    pops = 0;
    check("cnt_reset", {16'd0, words_o}, 32'd0);
    avail = 70000;
    for (int cyc = 0; cyc < 66000 && pops < 65537; cyc++) begin
      cycle(1'b0, 1'b1, 1'b1);
    end
    check("cnt_pops", pops, 65537);
    check("cnt_wrap", {16'd0, words_o}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    check("cnt_clear", {16'd0, words_o}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
